evt_packer_n: RTL and testbench

- Parametrised successor of the ALPIDE byte-to-word event packer in the readout datapath.
- Packs a byte stream into NBYTES-wide words and aligns every event start to a word boundary.
- Buffers words in an internal first-word-fall-through FIFO with a reserved closing slot, so that overflow mid-event truncates the event cleanly instead of corrupting it.
- Adds byte-valid count, truncation flag, fill level and loss counters on the 16-bit register bus.

---
 rtl/evt_packer_n.sv | 206 ++++++++++++++++++++
 tb/tb_evt_packer_n.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/evt_packer_n.sv
// -----------------------------------------------------------------------------
// evt_packer_n
//   Packs an incoming byte stream into NBYTES-wide words, aligning every event
//   start to a word boundary, and buffers the words in a first-word-fall-through
//   FIFO. The last FIFO slot is kept for event-closing words, so an overflow in
//   the middle of an event truncates it cleanly: the remaining bytes are dropped
//   and a dedicated closer word (trunc=1) marks the cut.
//
// Ports
//   clk_i, rst_ni        clock, synchronous active-low reset
//   reg_we_i/addr/data   16-bit register bus write side
//   reg_data_o           register read data, combinational from reg_addr_i
//   data_i, we_i         input byte and its valid strobe
//   evtdone_i            last byte of the event (qualified by we_i)
//   data_o               head word, byte 0 in bits [7:0]
//   vbytes_o             valid bytes in the head word (0 when empty)
//   evtdone_o, trunc_o   head word closes an event / is a truncation closer
//   re_i                 pop head word (ignored when empty)
//   full_o, empty_o      FIFO status
// -----------------------------------------------------------------------------
module evt_packer_n #(
  parameter int unsigned NBYTES   = 4,
  parameter int unsigned DEPTH    = 512,
  parameter logic [7:0]  PAD_BYTE = 8'hFF
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                reg_we_i,
  input  logic [7:0]          reg_addr_i,
  input  logic [15:0]         reg_data_i,
  output logic [15:0]         reg_data_o,
  input  logic [7:0]          data_i,
  input  logic                we_i,
  input  logic                evtdone_i,
  output logic [8*NBYTES-1:0] data_o,
  output logic [3:0]          vbytes_o,
  output logic                evtdone_o,
  output logic                trunc_o,
  input  logic                re_i,
  output logic                full_o,
  output logic                empty_o
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned FW   = AW + 1;
  localparam int unsigned WW   = 8 * NBYTES;
  localparam int unsigned EW   = WW + 6;        // {trunc, evtdone, vbytes[3:0], data}
  localparam logic [3:0]  LAST = 4'(NBYTES - 1);
  localparam int          NCTR = 6;             // NEV, NIN8, NINW, NOUTW, NTRUNC, NLOST

  typedef enum logic {ST_NORMAL = 1'b0, ST_DISCARD = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0]       lanes_q [NBYTES];
  logic [EW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [FW-1:0]    fill_q;
  logic [15:0]      ctr_q [NCTR];

  logic             cmd_wr, clr_all, cmd_clr;
  logic             room_data, room_close, pop;
  logic [WW-1:0]    close_word, wr_word;
  logic [3:0]       wr_vb;
  logic             wr_en, wr_ed, wr_tr, take_byte, inc_trunc, inc_lost;
  logic [NCTR-1:0]  ctr_inc;
  logic [EW-1:0]    head;

  // Register commands: CMD_RST behaves exactly like the reset pin.
  assign cmd_wr  = reg_we_i && (reg_addr_i == 8'h02);
  assign clr_all = !rst_ni || (cmd_wr && reg_data_i == 16'h0000);
  assign cmd_clr = cmd_wr && (reg_data_i == 16'h0001);

  // Admission looks at the fill before this edge; a same-cycle pop does not help.
  assign room_data  = fill_q < FW'(DEPTH - 1);
  assign room_close = fill_q < FW'(DEPTH);
  assign empty_o    = (fill_q == '0);
  assign full_o     = (fill_q == FW'(DEPTH));
  assign pop        = re_i && !empty_o;

  // Closing word: held lanes below cnt, the current byte in lane cnt, pad above.
  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
    assign close_word[8*gi +: 8] = (4'(gi) < cnt_q)  ? lanes_q[gi] :
                                   (4'(gi) == cnt_q) ? data_i      : PAD_BYTE;
  end

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (clr_all) state_q <= ST_NORMAL;
    else         state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_NORMAL:  if (we_i && cnt_q == LAST && !evtdone_i && !room_data) state_d = ST_DISCARD;
      ST_DISCARD: if (we_i && evtdone_i) state_d = ST_NORMAL;
      default:    state_d = ST_NORMAL;
    endcase
  end

  // FSM: outputs (word write, byte capture, loss/truncation events)
  always_comb begin
    wr_en     = 1'b0;
    wr_word   = close_word;
    wr_vb     = cnt_q + 4'd1;
    wr_ed     = evtdone_i;
    wr_tr     = 1'b0;
    take_byte = 1'b0;
    cnt_d     = cnt_q;
    inc_trunc = 1'b0;
    inc_lost  = 1'b0;
    case (state_q)
      ST_NORMAL: begin
        if (we_i) begin
          if (cnt_q == LAST || evtdone_i) begin
            cnt_d = '0;
            if (evtdone_i) begin
              if (room_close) wr_en = 1'b1;
              else            inc_lost = 1'b1;
            end else begin
              if (room_data) wr_en = 1'b1;
              else           inc_trunc = 1'b1;
            end
          end else begin
            take_byte = 1'b1;
            cnt_d     = cnt_q + 4'd1;
          end
        end
      end
      ST_DISCARD: begin
        cnt_d   = '0;
        wr_word = {NBYTES{PAD_BYTE}};
        wr_vb   = '0;
        wr_ed   = 1'b1;
        wr_tr   = 1'b1;
        if (we_i && evtdone_i) begin
          if (room_close) wr_en = 1'b1;
          else            inc_lost = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Partial word lanes; content is only meaningful below cnt, so no reset needed.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NBYTES; i++) begin
      if (take_byte && cnt_q == 4'(i)) lanes_q[i] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= {wr_tr, wr_ed, wr_vb, wr_word};
  end

  always_ff @(posedge clk_i) begin
    if (clr_all) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en, pop})
        2'b10:   fill_q <= fill_q + FW'(1);
        2'b01:   fill_q <= fill_q - FW'(1);
        default: fill_q <= fill_q;
      endcase
    end
  end

  assign ctr_inc = {inc_lost, inc_trunc, pop, wr_en, we_i, we_i && evtdone_i};

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NCTR; i++) begin
      if (clr_all || cmd_clr) ctr_q[i] <= '0;
      else if (ctr_inc[i])    ctr_q[i] <= ctr_q[i] + 16'd1;
    end
  end

  // Head word; flags and vbytes are forced low while empty.
  assign head      = mem_q[rd_ptr_q];
  assign data_o    = head[WW-1:0];
  assign vbytes_o  = empty_o ? 4'd0 : head[WW+3:WW];
  assign evtdone_o = !empty_o && head[WW+4];
  assign trunc_o   = !empty_o && head[WW+5];

  always_comb begin
    case (reg_addr_i)
      8'h00, 8'h02: reg_data_o = {8'(cnt_q), 5'b0, state_q == ST_DISCARD, empty_o, full_o};
      8'h03:        reg_data_o = ctr_q[0];
      8'h04:        reg_data_o = ctr_q[1];
      8'h05:        reg_data_o = ctr_q[2];
      8'h06:        reg_data_o = ctr_q[3];
      8'h07:        reg_data_o = ctr_q[4];
      8'h08:        reg_data_o = ctr_q[5];
      8'h09:        reg_data_o = 16'(fill_q);
      default:      reg_data_o = 16'hF001;
    endcase
  end

endmodule

// File: tb/tb_evt_packer_n.sv
// -----------------------------------------------------------------------------
// tb_evt_packer_n
//   Directed steps followed by a randomized phase for evt_packer_n (NBYTES=4,
//   DEPTH=4). A queue-based reference model tracks stored words, the partial
//   word bytes, the discard flag and the counters; every cycle the DUT outputs
//   and the full register map are compared against it.
// -----------------------------------------------------------------------------
module tb_evt_packer_n;

  localparam int         NB  = 4;
  localparam int         DEP = 4;
  localparam logic [7:0] PAD = 8'hFF;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          reg_we_i;
  logic [7:0]    reg_addr_i;
  logic [15:0]   reg_data_i;
  logic [15:0]   reg_data_o;
  logic [7:0]    data_i;
  logic          we_i;
  logic          evtdone_i;
  logic [8*NB-1:0] data_o;
  logic [3:0]    vbytes_o;
  logic          evtdone_o;
  logic          trunc_o;
  logic          re_i;
  logic          full_o;
  logic          empty_o;

  always #20 clk_i = ~clk_i;

  evt_packer_n #(.NBYTES(NB), .DEPTH(DEP), .PAD_BYTE(PAD)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .reg_we_i(reg_we_i), .reg_addr_i(reg_addr_i), .reg_data_i(reg_data_i),
    .reg_data_o(reg_data_o),
    .data_i(data_i), .we_i(we_i), .evtdone_i(evtdone_i),
    .data_o(data_o), .vbytes_o(vbytes_o), .evtdone_o(evtdone_o), .trunc_o(trunc_o),
    .re_i(re_i), .full_o(full_o), .empty_o(empty_o)
  );

  typedef struct packed {
    logic          tr;
    logic          ed;
    logic [3:0]    vb;
    logic [8*NB-1:0] data;
  } word_t;

  word_t       mq[$];
  logic [7:0]  mbytes[$];
  bit          mdisc;
  logic [15:0] m_nev, m_nin8, m_ninw, m_noutw, m_ntrunc, m_nlost;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    mbytes.delete();
    mdisc = 1'b0;
    m_nev = 0; m_nin8 = 0; m_ninw = 0; m_noutw = 0; m_ntrunc = 0; m_nlost = 0;
  endfunction

  function automatic void model_clr();
    m_nev = 0; m_nin8 = 0; m_ninw = 0; m_noutw = 0; m_ntrunc = 0; m_nlost = 0;
  endfunction

  // One clock edge of the specified behaviour.
  function automatic void model_edge(bit we, bit ed, logic [7:0] d, bit re);
    int    fill0 = mq.size();
    bit    do_pop = re && (fill0 > 0);
    bit    do_push = 1'b0;
    word_t w;
    w.data = {NB{PAD}}; w.vb = 0; w.ed = 1'b1; w.tr = 1'b1;
    if (we) begin
      m_nin8++;
      if (ed) m_nev++;
      if (mdisc) begin
        if (ed) begin
          if (fill0 < DEP) do_push = 1'b1;
          else             m_nlost++;
          mdisc = 1'b0;
        end
      end else begin
        mbytes.push_back(d);
        if (mbytes.size() == NB || ed) begin
          w.data = {NB{PAD}};
          for (int i = 0; i < mbytes.size(); i++) w.data[8*i +: 8] = mbytes[i];
          w.vb = 4'(mbytes.size());
          w.ed = ed;
          w.tr = 1'b0;
          mbytes.delete();
          if (fill0 < (ed ? DEP : DEP - 1)) do_push = 1'b1;
          else if (ed)                       m_nlost++;
          else begin
            m_ntrunc++;
            mdisc = 1'b1;
          end
        end
      end
    end
    if (do_pop) begin
      void'(mq.pop_front());
      m_noutw++;
    end
    if (do_push) begin
      mq.push_back(w);
      m_ninw++;
    end
  endfunction

  function automatic logic [15:0] mreg(input logic [7:0] a);
    logic [15:0] st;
    st = {8'(mbytes.size()), 5'b0, mdisc, mq.size() == 0, mq.size() == DEP};
    case (a)
      8'h00, 8'h02: return st;
      8'h03:        return m_nev;
      8'h04:        return m_nin8;
      8'h05:        return m_ninw;
      8'h06:        return m_noutw;
      8'h07:        return m_ntrunc;
      8'h08:        return m_nlost;
      8'h09:        return 16'(mq.size());
      default:      return 16'hF001;
    endcase
  endfunction

  // Compare outputs and the whole register map with the model.
  task automatic compare_all(input string ctx);
    logic [7:0] addrs [12];
    for (int i = 0; i < 11; i++) addrs[i] = 8'(i);
    addrs[11] = 8'($urandom_range(10, 255));
    chk({ctx, ".empty"}, 32'(empty_o), 32'(mq.size() == 0));
    chk({ctx, ".full"},  32'(full_o),  32'(mq.size() == DEP));
    if (mq.size() == 0) begin
      chk({ctx, ".vb"}, 32'(vbytes_o),  0);
      chk({ctx, ".ed"}, 32'(evtdone_o), 0);
      chk({ctx, ".tr"}, 32'(trunc_o),   0);
    end else begin
      chk({ctx, ".data"}, 32'(data_o),    32'(mq[0].data));
      chk({ctx, ".vb"},   32'(vbytes_o),  32'(mq[0].vb));
      chk({ctx, ".ed"},   32'(evtdone_o), 32'(mq[0].ed));
      chk({ctx, ".tr"},   32'(trunc_o),   32'(mq[0].tr));
    end
    for (int i = 0; i < 12; i++) begin
      reg_addr_i = addrs[i];
      #1;
      chk($sformatf("%s.reg%02h", ctx, addrs[i]), 32'(reg_data_o), 32'(mreg(addrs[i])));
    end
  endtask

  task automatic cyc(input bit we, input bit ed, input logic [7:0] d, input bit re);
    we_i = we; evtdone_i = ed; data_i = d; re_i = re;
    @(posedge clk_i);
    model_edge(we, ed, d, re);
    #1;
    we_i = 1'b0; evtdone_i = 1'b0; re_i = 1'b0;
    $display("cyc we=%0b ed=%0b d=%02h re=%0b -> fill=%0d", we, ed, d, re, mq.size());
    compare_all("cyc");
  endtask

  task automatic do_rst();
    rst_ni = 1'b0;
    @(posedge clk_i);
    model_reset();
    #1;
    rst_ni = 1'b1;
    $display("reset");
    compare_all("rst");
  endtask

  task automatic reg_write(input logic [7:0] a, input logic [15:0] d);
    reg_we_i = 1'b1; reg_addr_i = a; reg_data_i = d;
    @(posedge clk_i);
    if (a == 8'h02 && d == 16'h0000) model_reset();
    else if (a == 8'h02 && d == 16'h0001) model_clr();
    #1;
    reg_we_i = 1'b0;
    $display("regwr addr=%02h data=%04h", a, d);
    compare_all("regwr");
  endtask

  // Directed check of one register against a constant.
  task automatic creg(input string tag, input logic [7:0] a, input logic [15:0] exp);
    reg_addr_i = a;
    #1;
    chk(tag, 32'(reg_data_o), 32'(exp));
  endtask

  initial begin
    rst_ni = 1'b0; reg_we_i = 1'b0; reg_addr_i = '0; reg_data_i = '0;
    data_i = '0; we_i = 1'b0; evtdone_i = 1'b0; re_i = 1'b0;
    model_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    compare_all("init");
    creg("init.status", 8'h00, 16'h0002);

    // Bytes 01..06, event ends with 06.
    for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b0, 8'(i), 1'b0);
    cyc(1'b1, 1'b1, 8'h06, 1'b0);
    chk("t1.w0.data", 32'(data_o), 32'h04030201);
    chk("t1.w0.vb", 32'(vbytes_o), 4);
    chk("t1.w0.ed", 32'(evtdone_o), 0);
    creg("t1.nev", 8'h03, 16'd1);
    creg("t1.nin8", 8'h04, 16'd6);
    creg("t1.ninw", 8'h05, 16'd2);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t1.w1.data", 32'(data_o), 32'hFFFF0605);
    chk("t1.w1.vb", 32'(vbytes_o), 2);
    chk("t1.w1.ed", 32'(evtdone_o), 1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t1.empty", 32'(empty_o), 1);

    // Back-to-back single-byte events.
    cyc(1'b1, 1'b1, 8'hAA, 1'b0);
    cyc(1'b1, 1'b1, 8'hBB, 1'b0);
    chk("t2.w0.data", 32'(data_o), 32'hFFFFFFAA);
    chk("t2.w0.vb", 32'(vbytes_o), 1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t2.w1.data", 32'(data_o), 32'hFFFFFFBB);
    chk("t2.w1.ed", 32'(evtdone_o), 1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);

    // Overflow mid-event: 3 words kept, 4th dropped, closer in reserved slot.
    do_rst();
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(i + 1), 1'b0);
    creg("t3.status.disc", 8'h00, 16'h0004);
    cyc(1'b1, 1'b1, 8'h77, 1'b0);
    chk("t3.full", 32'(full_o), 1);
    creg("t3.fill", 8'h09, 16'd4);
    creg("t3.ntrunc", 8'h07, 16'd1);
    creg("t3.ninw", 8'h05, 16'd4);
    chk("t3.head", 32'(data_o), 32'h04030201);

    // Full FIFO: a 1-byte event is lost, contents unchanged.
    cyc(1'b1, 1'b1, 8'h55, 1'b0);
    creg("t4.nlost", 8'h08, 16'd1);
    creg("t4.fill", 8'h09, 16'd4);
    chk("t4.head", 32'(data_o), 32'h04030201);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    creg("t4.fill3", 8'h09, 16'd3);
    chk("t4.empty", 32'(empty_o), 0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t4.closer.data", 32'(data_o), 32'hFFFFFFFF);
    chk("t4.closer.vb", 32'(vbytes_o), 0);
    chk("t4.closer.ed", 32'(evtdone_o), 1);
    chk("t4.closer.tr", 32'(trunc_o), 1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);

    // Simultaneous push and pop at fill=2.
    cyc(1'b1, 1'b1, 8'h11, 1'b0);
    cyc(1'b1, 1'b1, 8'h22, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b1, 8'($urandom), 1'b1);
      creg("t5.fill", 8'h09, 16'd2);
    end
    creg("t5.ninw", 8'h05, 16'd14);
    creg("t5.noutw", 8'h06, 16'd12);

    // Reset pin mid-word.
    cyc(1'b1, 1'b0, 8'hA1, 1'b0);
    cyc(1'b1, 1'b0, 8'hA2, 1'b0);
    creg("t6.cnt2", 8'h00, 16'h0200);
    do_rst();
    creg("t6.status", 8'h00, 16'h0002);
    creg("t6.nev", 8'h03, 16'd0);
    creg("t6.nin8", 8'h04, 16'd0);
    cyc(1'b1, 1'b0, 8'hB1, 1'b0);
    cyc(1'b1, 1'b1, 8'hB2, 1'b0);
    chk("t6.head", 32'(data_o), 32'hFFFFB2B1);
    chk("t6.vb", 32'(vbytes_o), 2);

    // Same through CMD_RST.
    cyc(1'b1, 1'b0, 8'hA1, 1'b0);
    cyc(1'b1, 1'b0, 8'hA2, 1'b0);
    reg_write(8'h02, 16'h0000);
    creg("t7.status", 8'h00, 16'h0002);
    creg("t7.nin8", 8'h04, 16'd0);
    cyc(1'b1, 1'b0, 8'hB1, 1'b0);
    cyc(1'b1, 1'b1, 8'hB2, 1'b0);
    chk("t7.head", 32'(data_o), 32'hFFFFB2B1);

    // CMD_CLR leaves the FIFO alone; other writes do nothing.
    reg_write(8'h02, 16'h0001);
    creg("t8.nev", 8'h03, 16'd0);
    creg("t8.ninw", 8'h05, 16'd0);
    creg("t8.fill", 8'h09, 16'd1);
    chk("t8.head", 32'(data_o), 32'hFFFFB2B1);
    reg_write(8'h02, 16'h1234);
    reg_write(8'h03, 16'h0000);
    creg("t8.fill2", 8'h09, 16'd1);

    // Randomized traffic against the model.
    do_rst();
    for (int n = 0; n < 1500; n++) begin
      int r = $urandom_range(0, 99);
      if (r < 1) begin
        do_rst();
      end else if (r < 4) begin
        int k = $urandom_range(0, 3);
        if (k == 0)      reg_write(8'h02, 16'h0001);
        else if (k == 1) reg_write(8'h02, 16'h0000);
        else if (k == 2) reg_write(8'h02, 16'($urandom_range(2, 65535)));
        else             reg_write(8'($urandom_range(3, 255)), 16'($urandom));
      end else begin
        bit we = ($urandom_range(0, 99) < 75);
        bit ed = ($urandom_range(0, 99) < 25);
        bit re = ($urandom_range(0, 99) < ((n < 750) ? 30 : 60));
        cyc(we, ed, 8'($urandom), re);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
